// File: rtl/lzw_decompressor.sv
// Receive-side byte decoder: recovers (comp - OFFSET) ^ XOR_KEY through an input
// FIFO and a four-state decode FSM with a backpressured valid/ready output.
module lzw_decompressor #(
  parameter int         DEPTH   = 4,
  parameter logic [7:0] XOR_KEY = 8'h3C,
  parameter logic [7:0] OFFSET  = 8'h05
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  comp_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  data_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        done,
  output logic [15:0] byte_count,
  output logic [1:0]  fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; the source holds its payload stable and keeps valid high until then.

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PROCESS = 2'd2,
    FINISH  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  logic [7:0]  buffer;
  logic [7:0]  buffer_next;
  logic [7:0]  data_next;
  logic        valid_next;
  logic        done_next;
  logic [15:0] count_next;

  // Readiness looks only at occupancy, so a full FIFO refuses even when popping.
  assign in_ready   = (count != CW'(DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = in_valid & in_ready;
  assign fsm_state  = state;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= comp_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    buffer_next = buffer;
    data_next   = data_out;
    valid_next  = out_valid;
    done_next   = done;
    count_next  = byte_count;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        done_next = 1'b0;
        if (!fifo_empty) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        buffer_next = mem[rd_ptr];
        pop         = !fifo_empty;
        state_next  = PROCESS;
      end
      PROCESS: begin
        // 8-bit subtract: the borrow simply falls off the top.
        data_next  = (buffer - OFFSET) ^ XOR_KEY;
        valid_next = 1'b1;
        state_next = FINISH;
      end
      FINISH: begin
        if (out_ready) begin
          valid_next = 1'b0;
          done_next  = 1'b1;
          count_next = byte_count + 16'd1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buffer     <= '0;
      data_out   <= '0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
      byte_count <= '0;
    end else begin
      buffer     <= buffer_next;
      data_out   <= data_next;
      out_valid  <= valid_next;
      done       <= done_next;
      byte_count <= count_next;
    end
  end

endmodule
